shift_unit_seq: RTL and testbench
=================================

Name: shift_unit_seq

Overview:
- Iterative barrel-less shifter. It consumes the shift-amount word produced by the shift-amount select mux: rs/rt-derived, constant 16 for lui, shamt field, or memory-derived.
- Latches an operand and a shift amount on start, shifts one bit per clock, then pulses done with the result held stable.
- Sits in the datapath between the shift-amount/shift-source muxes and the write-back mux. Driven by the control unit FSM.

Parameters:
- WIDTH, 32, operand/result width.
- SHAMT_W, 5, number of low bits of the shift-amount word used (log2 WIDTH).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- shift_op  input  3  operation code, latched on accepted start.
- data_in  input  WIDTH  operand, latched on accepted start.
- shamt_in  input  WIDTH  shift-amount word from the select mux; only bits [SHAMT_W-1:0] are used, upper bits are ignored.
- busy  output  1  high while in SHIFT or DONE.
- done  output  1  one-cycle pulse, result valid.
- data_out  output  WIDTH  result register; holds its value until the next accepted start.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset.
- Reset values: state=IDLE, busy=0, done=0, data_out=0, counter=0, op=0.
- Reset mid-operation: on the next edge the block returns to IDLE with the reset values above. The in-flight result is discarded and no done pulse is produced.
- Op codes:
  - 001 SLL: zero fill from the LSB.
  - 010 SRL: zero fill from the MSB.
  - 011 SRA: MSB replicated.
  - 100 ROR.
  - 101 ROL.
  - 000/110/111 PASS: result = data_in, effective shamt forced to 0.
- State machine states: IDLE, SHIFT, DONE.
- IDLE:
  - On start=1, at the edge: data_out<=data_in, counter<=shamt_in[SHAMT_W-1:0], op latched.
  - Next state is DONE if the effective shamt is 0, else SHIFT.
  - start=0: remain in IDLE.
- SHIFT:
  - Each edge applies a 1-bit operation of the latched op to data_out and does counter<=counter-1.
  - When counter==1 at the edge, next state is DONE.
  - start is ignored in SHIFT.
- DONE:
  - done=1 for exactly this one cycle, and data_out holds the final result.
  - Next state is IDLE unconditionally.
  - start asserted during DONE is ignored. The requester must re-assert it in IDLE.
- Latency:
  - For effective shamt N>0, done is high in the (N+1)th cycle after the accepting edge.
  - For N=0, done is high in the cycle immediately after the accepting edge.
  - Maximum latency is 32 cycles (N=31).
- busy:
  - busy=1 in SHIFT and DONE, 0 in IDLE.
  - The control unit holds its state while busy=1 and done=0.
- Width rules:
  - The shift amount is taken modulo 2^SHAMT_W, so shamt_in=32 behaves as 0.
  - No result bits are lost except those shifted out. Rotates are lossless.
- Back-to-back: a start may be accepted in the IDLE cycle directly after DONE. There is no dead cycle beyond the DONE cycle.

Decomposition:
- Shared package holds:
  - shift op encodings: OP_PASS, OP_SLL, OP_SRL, OP_SRA, OP_ROR, OP_ROL.
  - FSM state encodings: ST_IDLE, ST_SHIFT, ST_DONE.
  - WIDTH/SHAMT_W defaults.
- One natural sub-module: shift1_comb. It is purely combinational: op + WIDTH-bit value in, 1-bit-shifted value out. The top level holds the FSM, counter and data_out register.

Test Plan:
- lui path: op=SLL, data_in=0x00001234, shamt_in=0x00000010, start 1 cycle -> busy rises next cycle; done pulses exactly 17 cycles after the accepting edge; data_out=0x12340000.
- op=SRA, data_in=0x80000000, shamt_in=4 -> data_out=0xF8000000 when done. Same with op=SRL -> 0x08000000.
- op=ROR, data_in=0x00000001, shamt_in=1 -> 0x80000000, done 2 cycles after accept. op=ROL, data_in=0x80000001, shamt_in=0x00000024 (upper bits ignored, N=4) -> 0x00000018.
- shamt_in=0 with op=SLL, data_in=0xDEADBEEF -> done the next cycle, data_out=0xDEADBEEF. Unused op 111 with shamt 9 -> same one-cycle pass.
- Start held high throughout a 16-cycle shift -> no restart mid-shift, and no second accept in DONE; a new accept occurs only in the following IDLE cycle. data_out is stable between done and the next accept.
- reset asserted at cycle 5 of a 16-bit shift -> next cycle busy=0, done=0, data_out=0, state IDLE; no done pulse is ever produced for the aborted operation.

Source files
------------

// File: rtl/shift_unit_seq_pkg.sv
// Shared encodings for the iterative shifter: op codes, FSM states and size defaults.
package shift_unit_seq_pkg;

  localparam int unsigned DEF_WIDTH   = 32;
  localparam int unsigned DEF_SHAMT_W = 5;

  localparam logic [2:0] OP_PASS = 3'b000;
  localparam logic [2:0] OP_SLL  = 3'b001;
  localparam logic [2:0] OP_SRL  = 3'b010;
  localparam logic [2:0] OP_SRA  = 3'b011;
  localparam logic [2:0] OP_ROR  = 3'b100;
  localparam logic [2:0] OP_ROL  = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Unused codes (000/110/111) behave as a pass-through with zero shift.
  function automatic logic is_shift_op(input logic [2:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA) ||
           (op == OP_ROR) || (op == OP_ROL);
  endfunction

endpackage

// File: rtl/shift_unit_seq_shift1_comb.sv
// One-bit shift/rotate step applied once per clock by the sequential shifter.
module shift_unit_seq_shift1_comb
  import shift_unit_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    result = value;
    case (op)
      OP_SLL:  result = {value[WIDTH-2:0], 1'b0};
      OP_SRL:  result = {1'b0, value[WIDTH-1:1]};
      OP_SRA:  result = {value[WIDTH-1], value[WIDTH-1:1]};
      OP_ROR:  result = {value[0], value[WIDTH-1:1]};
      OP_ROL:  result = {value[WIDTH-2:0], value[WIDTH-1]};
      default: result = value;
    endcase
  end

endmodule

// File: rtl/shift_unit_seq.sv
// Iterative shifter: latches operand and amount on start, shifts one bit per clock,
// then pulses done for one cycle with the result held in data_out.
module shift_unit_seq
  import shift_unit_seq_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned SHAMT_W = DEF_SHAMT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       shift_op,
  input  logic [WIDTH-1:0] data_in,
  input  logic [WIDTH-1:0] shamt_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] data_out
);

  state_e             state_q, state_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [2:0]         op_q, op_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [WIDTH-1:0]   step;
  logic [SHAMT_W-1:0] eff_shamt;

  shift_unit_seq_shift1_comb #(
    .WIDTH (WIDTH)
  ) u_shift1 (
    .op     (op_q),
    .value  (data_q),
    .result (step)
  );

  // Upper shamt bits are dropped, so the amount is taken modulo 2^SHAMT_W.
  assign eff_shamt = is_shift_op(shift_op) ? shamt_in[SHAMT_W-1:0] : '0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    data_d  = data_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          data_d  = data_in;
          op_d    = shift_op;
          cnt_d   = eff_shamt;
          state_d = (eff_shamt == '0) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        data_d = step;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == SHAMT_W'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_PASS;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      data_q  <= data_d;
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign data_out = data_q;

endmodule

// File: tb/tb_shift_unit_seq.sv
// Scoreboard bench for shift_unit_seq: driver pushes model results, monitor pops on done.
module tb_shift_unit_seq;

  typedef struct {
    logic [31:0] res;
    int unsigned acc;
    int unsigned n;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  shift_op;
  logic [31:0] data_in;
  logic [31:0] shamt_in;
  logic        busy;
  logic        done;
  logic [31:0] data_out;

  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  exp_t        q[$];
  logic [31:0] last_res;
  bit          have_res = 0;

  shift_unit_seq dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .shift_op (shift_op),
    .data_in  (data_in),
    .shamt_in (shamt_in),
    .busy     (busy),
    .done     (done),
    .data_out (data_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model from the op definitions, using plain shift operators.
  function automatic exp_t model(input logic [2:0] op, input logic [31:0] d,
                                 input logic [31:0] sh);
    exp_t e;
    int unsigned n;
    n = (op >= 3'd1 && op <= 3'd5) ? (sh % 32) : 0;
    case (op)
      3'd1:    e.res = d << n;
      3'd2:    e.res = d >> n;
      3'd3:    e.res = $unsigned($signed(d) >>> n);
      3'd4:    e.res = (n == 0) ? d : ((d >> n) | (d << (32 - n)));
      3'd5:    e.res = (n == 0) ? d : ((d << n) | (d >> (32 - n)));
      default: e.res = d;
    endcase
    e.n   = n;
    e.acc = 0;
    return e;
  endfunction

  task automatic wait_idle();
    int k;
    for (k = 0; k < 100 && busy !== 1'b0; k++) begin
      @(posedge clk);
      #1;
    end
    if (busy !== 1'b0) begin
      n_checks++;
      n_fail++;
      $display("FAIL idle_timeout: busy=%b after 100 cycles, required 0", busy);
    end
  endtask

  // With hold set, start stays high afterwards with different operands.
  task automatic issue(input logic [2:0] op, input logic [31:0] d, input logic [31:0] sh,
                       input bit hold);
    exp_t e;
    wait_idle();
    start    = 1'b1;
    shift_op = op;
    data_in  = d;
    shamt_in = sh;
    @(posedge clk);
    #1;
    e     = model(op, d, sh);
    e.acc = cyc;
    q.push_back(e);
    if (!hold) begin
      start = 1'b0;
    end else begin
      shift_op = op ^ 3'b011;
      data_in  = ~d;
      shamt_in = sh + 32'd3;
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset === 1'b1) begin
        have_res = 0;
      end else if (done === 1'b1) begin
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: done=1 data_out=%h with no pending request", data_out);
        end else begin
          e = q.pop_front();
          check("result", data_out, e.res);
          check("latency", cyc - e.acc, e.n);
          check("busy_in_done", {31'd0, busy}, 32'd1);
          last_res = data_out;
          have_res = 1;
        end
      end else if (busy === 1'b0 && have_res) begin
        check("hold_after_done", data_out, last_res);
      end
    end
  end

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    shift_op = 3'd0;
    data_in  = '0;
    shamt_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_data", data_out, 32'd0);
    reset = 1'b0;

    // lui path
    issue(3'd1, 32'h0000_1234, 32'h0000_0010, 0);
    check("busy_rise", {31'd0, busy}, 32'd1);
    issue(3'd3, 32'h8000_0000, 32'd4, 0);
    issue(3'd2, 32'h8000_0000, 32'd4, 0);
    issue(3'd4, 32'h0000_0001, 32'd1, 0);
    issue(3'd5, 32'h8000_0001, 32'h0000_0024, 0);
    issue(3'd1, 32'hDEAD_BEEF, 32'd0, 0);
    issue(3'd7, 32'hDEAD_BEEF, 32'd9, 0);
    issue(3'd2, 32'hCAFE_F00D, 32'd32, 0);

    // start held high through a 16-bit shift and into the following IDLE cycle
    issue(3'd2, 32'hF0F0_1234, 32'd16, 1);
    issue(3'd4, 32'h1357_9BDF, 32'd7, 0);

    // reset in the middle of a 16-bit shift
    issue(3'd1, 32'h0000_ABCD, 32'd16, 0);
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    void'(q.pop_back());
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_data", data_out, 32'd0);
    repeat (25) @(posedge clk);
    #1;

    for (int i = 0; i < 60; i++) begin
      issue(3'($urandom_range(0, 7)), $urandom, $urandom, 0);
    end

    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    check("queue_empty", q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
